// File: rtl/repl_select.sv
// Victim way selector for a set-associative cache.
// MODE 0 picks a pseudo-random way from a Galois LFSR, MODE 1 walks a
// per-set tree-PLRU. An invalid way always wins over either policy.
// The result is registered one cycle after the request.
module repl_select #(
  parameter int SET_NUM    = 64,
  parameter int SET_SIZE   = 4,
  parameter int WAY_WIDTH  = $clog2(SET_SIZE),
  parameter int SET_WIDTH  = $clog2(SET_NUM),
  parameter int LFSR_WIDTH = 5,
  parameter logic [LFSR_WIDTH-1:0] TAPS = 5'b00100,
  parameter int SEED       = 1,
  parameter int MODE       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [SET_WIDTH-1:0]  req_set,
  input  logic [SET_SIZE-1:0]   valid_bits,
  input  logic                  touch_valid,
  input  logic [SET_WIDTH-1:0]  touch_set,
  input  logic [WAY_WIDTH-1:0]  touch_way,
  output logic                  victim_valid,
  output logic [WAY_WIDTH-1:0]  victim_way,
  output logic [LFSR_WIDTH-1:0] lfsr_q
);

  if (SEED == 0) begin : g_bad_seed
    $fatal(1, "repl_select: SEED must be nonzero");
  end

  // One row per set. Nodes 0..SET_SIZE-2 are the heap-ordered PLRU bits;
  // the top bit is spare so node indices fit in WAY_WIDTH bits.
  logic [SET_SIZE-1:0]   plru_mem [SET_NUM];
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [SET_SIZE-1:0]   touched_row;
  logic [WAY_WIDTH-1:0]  plru_way;
  logic [WAY_WIDTH-1:0]  invalid_way;
  logic                  has_invalid;
  logic [WAY_WIDTH-1:0]  victim_next;

  // Walk from the root: bit 0 steps to the lower child, bit 1 to the upper.
  // The sequence of decisions, MSB first, is the leaf (way) index.
  function automatic logic [WAY_WIDTH-1:0] plru_leaf(input logic [SET_SIZE-1:0] row);
    logic [WAY_WIDTH-1:0] node;
    logic [WAY_WIDTH-1:0] way;
    node = '0;
    way  = '0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      way[WAY_WIDTH-1-l] = row[node];
      node = (node << 1) + WAY_WIDTH'(1) + WAY_WIDTH'(row[node]);
    end
    return way;
  endfunction

  // Rewrite every node on the path to the touched way so it points away.
  function automatic logic [SET_SIZE-1:0] plru_touch(input logic [SET_SIZE-1:0] row,
                                                     input logic [WAY_WIDTH-1:0] way);
    logic [SET_SIZE-1:0]  r;
    logic [WAY_WIDTH-1:0] node;
    r    = row;
    node = '0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      r[node] = ~way[WAY_WIDTH-1-l];
      node = (node << 1) + WAY_WIDTH'(1) + WAY_WIDTH'(way[WAY_WIDTH-1-l]);
    end
    return r;
  endfunction

  // Galois LFSR step: shift right, feed bit 0 back through the tap mask.
  always_comb begin
    lfsr_next = '0;
    lfsr_next[LFSR_WIDTH-1] = lfsr_q[0];
    for (int i = 0; i < LFSR_WIDTH - 1; i++) begin
      lfsr_next[i] = lfsr_q[i+1] ^ (TAPS[i] & lfsr_q[0]);
    end
  end

  // Victim choice: lowest invalid way first, otherwise the mode's policy.
  // The PLRU read uses the stored row, so a same-cycle touch is not seen.
  always_comb begin
    has_invalid = ~&valid_bits;
    invalid_way = '0;
    for (int i = SET_SIZE - 1; i >= 0; i--) begin
      if (!valid_bits[i]) invalid_way = WAY_WIDTH'(i);
    end
    plru_way    = plru_leaf(plru_mem[req_set]);
    touched_row = plru_touch(plru_mem[touch_set], touch_way);
    if (has_invalid)    victim_next = invalid_way;
    else if (MODE == 1) victim_next = plru_way;
    else                victim_next = lfsr_q[WAY_WIDTH-1:0];
  end

  // LFSR and registered victim result.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q       <= LFSR_WIDTH'(SEED);
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      lfsr_q       <= lfsr_next;
      victim_valid <= req_valid;
      if (req_valid) victim_way <= victim_next;
    end
  end

  // PLRU state; only touches modify it, and only in PLRU mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SET_NUM; s++) plru_mem[s] <= '0;
    end else if (MODE == 1 && touch_valid) begin
      plru_mem[touch_set] <= touched_row;
    end
  end

endmodule

// File: tb/tb_repl_select.sv
// Bench for repl_select: one random-mode and one PLRU-mode instance share
// stimulus and are compared every cycle against a behavioural model.
module tb_repl_select;
  localparam int SN = 64, SS = 4, WW = 2, SW = 6, LW = 5;
  localparam int TAPS_I = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [SW-1:0] req_set = '0;
  logic [SS-1:0] valid_bits = '0;
  logic          touch_valid = 1'b0;
  logic [SW-1:0] touch_set = '0;
  logic [WW-1:0] touch_way = '0;
  logic          vv0, vv1;
  logic [WW-1:0] vw0, vw1;
  logic [LW-1:0] lq0, lq1;

  repl_select #(.MODE(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_set(req_set),
    .valid_bits(valid_bits), .touch_valid(touch_valid), .touch_set(touch_set),
    .touch_way(touch_way), .victim_valid(vv0), .victim_way(vw0), .lfsr_q(lq0));

  repl_select #(.MODE(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_set(req_set),
    .valid_bits(valid_bits), .touch_valid(touch_valid), .touch_set(touch_set),
    .touch_way(touch_way), .victim_valid(vv1), .victim_way(vw1), .lfsr_q(lq1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model state
  int          m_lfsr = 1;
  bit          m_valid = 0;
  int          m_way0 = 0, m_way1 = 0;
  bit [SS-2:0] m_tree [SN];
  bit          model_live = 0;
  int          m_inv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest_invalid(input logic [SS-1:0] vb);
    for (int i = 0; i < SS; i++) if (!vb[i]) return i;
    return -1;
  endfunction

  function automatic int plru_victim(input int s);
    int n = 0;
    while (n < SS - 1) n = 2 * n + 1 + int'(m_tree[s][n]);
    return n - (SS - 1);
  endfunction

  task automatic plru_touch(input int s, input int w);
    int c = w + SS - 1;
    int p;
    while (c > 0) begin
      p = (c - 1) / 2;
      m_tree[s][p] = (c == 2 * p + 1);  // came from lower child -> point upper
      c = p;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_lfsr = 1;
      for (int s = 0; s < SN; s++) m_tree[s] = '0;
      m_valid = 0;
      m_way0 = 0;
      m_way1 = 0;
      model_live = 1;
    end else begin
      if (req_valid) begin
        m_inv  = lowest_invalid(valid_bits);
        m_way0 = (m_inv >= 0) ? m_inv : (m_lfsr % SS);
        m_way1 = (m_inv >= 0) ? m_inv : plru_victim(int'(req_set));
      end
      m_valid = req_valid;
      if (touch_valid) plru_touch(int'(touch_set), int'(touch_way));
      m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? (16 | TAPS_I) : 0);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("lfsr_m0", 32'(lq0), 32'(m_lfsr));
      chk("lfsr_m1", 32'(lq1), 32'(m_lfsr));
      chk("valid_m0", 32'(vv0), 32'(m_valid));
      chk("valid_m1", 32'(vv1), 32'(m_valid));
      chk("way_m0", 32'(vw0), 32'(m_way0));
      chk("way_m1", 32'(vw1), 32'(m_way1));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_inputs();
    req_valid = 0; touch_valid = 0; req_set = '0; touch_set = '0;
    touch_way = '0; valid_bits = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    cyc = 0;
  endtask

  task automatic req(input int s, input logic [SS-1:0] vb);
    req_valid = 1; req_set = SW'(s); valid_bits = vb;
  endtask

  task automatic touch(input int s, input int w);
    touch_valid = 1; touch_set = SW'(s); touch_way = WW'(w);
  endtask

  initial begin
    do_reset();
    chk("rst_lfsr", 32'(lq0), 32'h01);
    chk("rst_valid", 32'(vv1), 32'd0);
    chk("rst_way", 32'(vw1), 32'd0);
    step(); chk("lfsr_seq1", 32'(lq0), 32'h14);
    step(); chk("lfsr_seq2", 32'(lq0), 32'h0A);
    step(); chk("lfsr_seq3", 32'(lq0), 32'h05);
    step(); chk("lfsr_seq4", 32'(lq0), 32'h16);
    req(3, 4'hF); step(); req_valid = 0;
    chk("rand_at_16", 32'(vw0), 32'd2);
    chk("rand_valid", 32'(vv0), 32'd1);
    chk("plru_first", 32'(vw1), 32'd0);
    touch(3, 0); step(); touch_valid = 0;
    chk("no_req_valid", 32'(vv1), 32'd0);
    req(3, 4'hF); step(); req_valid = 0;
    chk("plru_after_t0", 32'(vw1), 32'd2);
    touch(3, 2); step(); touch_valid = 0;
    req(3, 4'hF); step(); req_valid = 0;
    chk("plru_after_t2", 32'(vw1), 32'd1);
    touch(3, 1); step(); touch_valid = 0;
    req(3, 4'hF); step(); req_valid = 0;
    chk("plru_after_t1", 32'(vw1), 32'd3);
    req(5, 4'b0000); step();
    chk("inv_all", 32'(vw0), 32'd0);
    req(5, 4'b1011); step(); req_valid = 0;
    chk("inv_1011_m0", 32'(vw0), 32'd2);
    chk("inv_1011_m1", 32'(vw1), 32'd2);
    step();
    chk("hold_way", 32'(vw0), 32'd2);
    chk("hold_valid", 32'(vv0), 32'd0);
    req(5, 4'hF); step(); req_valid = 0;
    chk("set_indep", 32'(vw1), 32'd0);
    while (cyc < 31) step();
    chk("lfsr_period", 32'(lq0), 32'h01);

    do_reset();
    touch(3, 0); req(3, 4'hF); step(); touch_valid = 0; req_valid = 0;
    chk("same_cyc_pre", 32'(vw1), 32'd0);
    req(3, 4'hF); step(); req_valid = 0;
    chk("same_cyc_post", 32'(vw1), 32'd2);

    reset = 1; req(3, 4'hF); touch(3, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0; clear_inputs();
    chk("rst_req_valid", 32'(vv0), 32'd0);
    chk("rst_req_lfsr", 32'(lq1), 32'h01);
    req(3, 4'hF); step(); req_valid = 0;
    chk("rst_touch_ign", 32'(vw1), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 149) == 0);
      req_valid   = 1'($urandom);
      req_set     = ($urandom_range(0, 3) == 0) ? SW'($urandom) : SW'($urandom_range(0, 3));
      valid_bits  = ($urandom_range(0, 2) != 0) ? 4'hF : SS'($urandom);
      touch_valid = 1'($urandom);
      touch_set   = ($urandom_range(0, 3) == 0) ? SW'($urandom) : SW'($urandom_range(0, 3));
      touch_way   = WW'($urandom);
      step();
    end
    reset = 0;
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/repl_select.md
REPL_SELECT -- requirements
Module: repl_select

Interface
REQ-001 The block SHALL have parameter SET_NUM, default 64: number of cache sets, power of two, at least 2.
REQ-002 The block SHALL have parameter SET_SIZE, default 4: ways per set, power of two, at least 2.
REQ-003 The block SHALL have parameter WAY_WIDTH, default $clog2(SET_SIZE): way index width.
REQ-004 The block SHALL have parameter SET_WIDTH, default $clog2(SET_NUM): set index width.
REQ-005 The block SHALL have parameter LFSR_WIDTH, default 5: LFSR width, at least WAY_WIDTH.
REQ-006 The block SHALL have parameter TAPS, default 5'b00100: Galois feedback mask of width LFSR_WIDTH.
REQ-007 The block SHALL have parameter SEED, default 1: LFSR reset value; it must be nonzero, and an elaboration assertion enforces this.
REQ-008 The block SHALL have parameter MODE, default 0: 0 = pseudo-random replacement, 1 = tree-PLRU replacement.
REQ-009 clk, input, 1: the single clock; all state updates on its rising edge.
REQ-010 reset, input, 1: synchronous, active-high reset.
REQ-011 req_valid, input, 1: victim request for req_set this cycle.
REQ-012 req_set, input, SET_WIDTH: set index of the request.
REQ-013 valid_bits, input, SET_SIZE: line-valid bits of req_set; bit i belongs to way i.
REQ-014 touch_valid, input, 1: way touch_way of touch_set was hit or filled.
REQ-015 touch_set, input, SET_WIDTH: set index of the touch.
REQ-016 touch_way, input, WAY_WIDTH: way index of the touch.
REQ-017 victim_valid, output, 1: registered; victim_way holds a fresh result.
REQ-018 victim_way, output, WAY_WIDTH: registered way chosen for replacement.
REQ-019 lfsr_q, output, LFSR_WIDTH: current LFSR state.

Function
REQ-020 The LFSR SHALL advance every cycle that reset is low: q_next[W-1] = q[0] and q_next[i] = q[i+1] ^ (TAPS[i] & q[0]) for i < W-1.
REQ-021 With the default parameters the LFSR SHALL be maximal-length with period 31 and SHALL never reach 0.
REQ-022 In MODE 1 the block SHALL hold SET_SIZE-1 PLRU bits per set, heap-ordered with node 0 at the root and node n having children 2n+1 and 2n+2.
REQ-023 PLRU traversal SHALL step to the lower-index subtree when a node bit is 0 and to the upper-index subtree when it is 1; the leaf reached is the PLRU way.
REQ-024 When touch_valid is high, every node on the path to touch_way in touch_set SHALL be written at the clock edge to point away from touch_way.
REQ-025 Touches SHALL be accepted in both modes; in MODE 0 they SHALL have no effect.
REQ-026 Victim selection priority 1: if any valid_bits bit is 0, the victim SHALL be the lowest-index invalid way, in both modes.
REQ-027 Victim selection priority 2, MODE 0: the victim SHALL be lfsr_q[WAY_WIDTH-1:0] as sampled in the request cycle.
REQ-028 Victim selection priority 2, MODE 1: the victim SHALL be the PLRU way of req_set as it stands before any same-cycle touch.
REQ-029 Latency SHALL be exactly 1 cycle: a request in cycle N gives victim_valid=1 and victim_way in cycle N+1.
REQ-030 victim_valid SHALL be 0 in any cycle not preceded by a request.
REQ-031 victim_way SHALL hold its last value until the next request.
REQ-032 Back-to-back requests SHALL each be answered in the following cycle; no request is dropped and there is no stall.
REQ-033 A request SHALL NOT modify PLRU state; the requester issues a touch on the fill.
REQ-034 Same-cycle touch and request to the same set SHALL return the pre-touch victim; the touch SHALL take effect at that edge.
REQ-035 Touches to different sets SHALL be independent of one another.

Reset
REQ-036 On reset the LFSR SHALL load SEED, all PLRU bits SHALL clear to 0, victim_valid SHALL clear to 0 and victim_way SHALL clear to 0.
REQ-037 A request or touch presented in a reset cycle SHALL be ignored, so victim_valid=0 in the following cycle.

Verification
REQ-038 Release reset with defaults and SEED=1 -> lfsr_q = 0x01, 0x14, 0x0A, 0x05, 0x16 on consecutive cycles, and 0x01 again 31 cycles after release.
REQ-039 MODE 0, valid_bits=4'b1011 -> victim_way=2 one cycle later; valid_bits=4'b0000 -> victim_way=0.
REQ-040 MODE 0, all valid, request in the cycle lfsr_q=0x16 -> victim_way=2 next cycle.
REQ-041 MODE 1, set 3 all valid after reset: request gives way 0; touch 0 then request gives way 2; touch 2 then request gives way 1; touch 1 then request gives way 3.
REQ-042 MODE 1, touch set 3 way 0 and request set 3 in the same cycle after reset -> victim_way=0; a request in the next cycle -> victim_way=2.
REQ-043 Request and reset in the same cycle -> victim_valid=0 next cycle and lfsr_q=SEED; a touch in the reset cycle leaves the PLRU bits at 0.
